spike_isi_monitor: RTL and testbench

- Downstream consumer of the neuron core's `spike` output bus; only bit 0 is meaningful.
- Converts spikes into two readout streams:
  - inter-spike intervals (ISI), buffered in a small FIFO and drained over a valid/ready handshake;
  - a windowed firing-rate count.
- Sits between the neuron and the tile output mux / host readout logic.

---
 rtl/snn_pkg.sv | 13 +
 rtl/isi_fifo.sv | 60 ++++++
 rtl/spike_isi_monitor.sv | 102 ++++++++++
 tb/tb_spike_isi_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared widths and helpers for the spiking-neuron tile.
// The saturating increment is reused by every neuron-side counter.
package snn_pkg;

    localparam int unsigned SPIKE_W = 8;
    localparam int unsigned ISI_W   = 8;
    localparam logic [ISI_W-1:0] ISI_MAX = 8'hFF;

    function automatic logic [ISI_W-1:0] sat_inc(input logic [ISI_W-1:0] v);
        return (v == ISI_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/isi_fifo.sv
// DEPTH x WIDTH synchronous FIFO with a combinational head.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module isi_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spike_isi_monitor.sv
// Turns the neuron spike level into inter-spike intervals (buffered) and a windowed rate.
// ena freezes interval and window counting; FIFO drain is never gated.
module spike_isi_monitor
    import snn_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIN   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SPIKE_W-1:0] spike_in,
    input  logic               ena,
    output logic [ISI_W-1:0]   isi_data,
    output logic               isi_valid,
    input  logic               isi_ready,
    output logic [7:0]         rate,
    output logic               rate_valid,
    output logic               overflow
);

    localparam logic [7:0] WIN_LAST = 8'(WIN - 1);

    logic             r_spike_d;
    logic             r_armed;
    logic [ISI_W-1:0] r_isi_cnt;
    logic [7:0]       r_win_cnt;
    logic [7:0]       r_spk_cnt;
    logic [7:0]       r_rate;
    logic             r_rate_valid;
    logic             r_overflow;

    logic             w_event;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_unused_spike;

    assign w_unused_spike = ^spike_in[SPIKE_W-1:1];

    assign w_event   = ena & spike_in[0] & ~r_spike_d;
    assign w_push    = w_event & r_armed;
    assign isi_valid = ~w_empty;
    assign w_pop     = isi_valid & isi_ready;

    isi_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ISI_W)
    ) u_isi_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (r_isi_cnt),
        .i_pop   (w_pop),
        .o_rdata (isi_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Edge history tracks the raw level even while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_d  <= 1'b0;
            r_armed    <= 1'b0;
            r_isi_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_spike_d <= spike_in[0];
            if (w_event) r_armed <= 1'b1;
            if (ena) r_isi_cnt <= w_event ? ISI_W'(1) : sat_inc(r_isi_cnt);
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // An event on the closing cycle belongs to the closing window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
        end else begin
            r_rate_valid <= 1'b0;
            if (ena) begin
                if (r_win_cnt == WIN_LAST) begin
                    r_win_cnt    <= '0;
                    r_spk_cnt    <= '0;
                    r_rate       <= w_event ? sat_inc(r_spk_cnt) : r_spk_cnt;
                    r_rate_valid <= 1'b1;
                end else begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    if (w_event) r_spk_cnt <= sat_inc(r_spk_cnt);
                end
            end
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_spike_isi_monitor.sv
// Directed bench for spike_isi_monitor (DEPTH=4, WIN=64): interval table plus hand sequences.
module tb_spike_isi_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] spike_in = 8'h00;
    logic       ena = 1'b1;
    logic       isi_ready = 1'b0;
    logic [7:0] isi_data;
    logic       isi_valid;
    logic [7:0] rate;
    logic       rate_valid;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         gap;
        logic [7:0] exp_isi;
    } vec_t;

    vec_t vecs[8];

    spike_isi_monitor #(
        .DEPTH (4),
        .WIN   (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .ena        (ena),
        .isi_data   (isi_data),
        .isi_valid  (isi_valid),
        .isi_ready  (isi_ready),
        .rate       (rate),
        .rate_valid (rate_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Quiet cycles carry junk in the ignored bits; event lands gap cycles after the last one.
    task automatic ev(input int gap);
        spike_in = 8'hFE;
        repeat (gap - 1) tick();
        spike_in = 8'h01;
        tick();
        spike_in = 8'h00;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        spike_in  = 8'h00;
        ena       = 1'b1;
        isi_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev_cyc[7];
        int exp_drain[4];
        logic hit;

        vecs[0] = '{5, 8'd5};
        vecs[1] = '{10, 8'd10};
        vecs[2] = '{2, 8'd2};
        vecs[3] = '{7, 8'd7};
        vecs[4] = '{100, 8'd100};
        vecs[5] = '{255, 8'd255};
        vecs[6] = '{256, 8'd255};
        vecs[7] = '{300, 8'd255};

        // Reset values and interval table.
        do_reset();
        chk("rst_isi_valid", isi_valid, 0);
        chk("rst_isi_data", isi_data, 0);
        chk("rst_rate", rate, 0);
        chk("rst_rate_valid", rate_valid, 0);
        chk("rst_overflow", overflow, 0);
        isi_ready = 1'b1;
        ev(11);
        chk("arm_no_push", isi_valid, 0);
        for (int i = 0; i < 8; i++) begin
            ev(vecs[i].gap);
            chk($sformatf("vec%0d_valid", i), isi_valid, 1);
            chk($sformatf("vec%0d_isi", i), isi_data, vecs[i].exp_isi);
        end
        chk("table_overflow", overflow, 0);

        // Held spike level yields a single event.
        do_reset();
        isi_ready = 1'b1;
        repeat (10) tick();
        spike_in = 8'hFF;
        repeat (11) tick();
        chk("held_no_push", isi_valid, 0);
        spike_in = 8'h00;
        repeat (9) tick();
        spike_in = 8'h01;
        tick();
        spike_in = 8'h00;
        chk("held_valid", isi_valid, 1);
        chk("held_isi", isi_data, 20);
        tick();
        chk("held_single", isi_valid, 0);

        // Fill, push+pop at full, overflow drop, drain with ena low.
        do_reset();
        repeat (5) ev(3);
        chk("fill_valid", isi_valid, 1);
        chk("fill_head", isi_data, 3);
        chk("fill_no_ovf", overflow, 0);
        spike_in = 8'h00;
        repeat (3) tick();
        spike_in = 8'h01;
        isi_ready = 1'b1;
        tick();
        spike_in = 8'h00;
        isi_ready = 1'b0;
        chk("full_pushpop_no_ovf", overflow, 0);
        ev(3);
        chk("drop_ovf", overflow, 1);
        ena = 1'b0;
        isi_ready = 1'b1;
        exp_drain = '{3, 3, 3, 4};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), isi_valid, 1);
            chk($sformatf("drain%0d_isi", i), isi_data, exp_drain[i]);
            tick();
        end
        chk("drain_empty", isi_valid, 0);
        chk("drain_ovf_sticky", overflow, 1);

        // Rate window, last-cycle event counted in closing window.
        do_reset();
        isi_ready = 1'b1;
        ev_cyc = '{2, 10, 20, 30, 40, 50, 63};
        for (int c = 0; c < 64; c++) begin
            hit = 1'b0;
            for (int k = 0; k < 7; k++) if (ev_cyc[k] == c) hit = 1'b1;
            spike_in = {7'h00, hit};
            tick();
            if (c < 63) chk($sformatf("win0_rv_c%0d", c), rate_valid, 0);
        end
        spike_in = 8'h00;
        chk("win0_rate_valid", rate_valid, 1);
        chk("win0_rate", rate, 7);
        tick();
        chk("win0_rv_one_cycle", rate_valid, 0);
        chk("win0_rate_hold", rate, 7);
        for (int c = 65; c < 128; c++) begin
            spike_in = (c == 70 || c == 100) ? 8'h01 : 8'h00;
            tick();
        end
        spike_in = 8'h00;
        chk("win1_rate_valid", rate_valid, 1);
        chk("win1_rate", rate, 2);

        // Freeze excluded from interval and window.
        do_reset();
        isi_ready = 1'b1;
        for (int r = 0; r < 84; r++) begin
            ena = !(r >= 10 && r < 30);
            spike_in = (r == 0 || r == 15 || r == 50) ? 8'h01 : 8'h00;
            tick();
            if (r == 50) begin
                chk("freeze_valid", isi_valid, 1);
                chk("freeze_isi", isi_data, 30);
            end
            if (r == 63) chk("freeze_no_early_rate", rate_valid, 0);
        end
        ena = 1'b1;
        spike_in = 8'h00;
        chk("freeze_rate_valid", rate_valid, 1);
        chk("freeze_rate", rate, 2);

        // Asynchronous reset mid-cycle with three entries queued.
        do_reset();
        repeat (6) ev(3);
        isi_ready = 1'b1;
        tick();
        isi_ready = 1'b0;
        repeat (45) tick();
        chk("pre_rst_valid", isi_valid, 1);
        chk("pre_rst_rate", rate, 6);
        chk("pre_rst_ovf", overflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", isi_valid, 0);
        chk("arst_data", isi_data, 0);
        chk("arst_rate", rate, 0);
        chk("arst_rate_valid", rate_valid, 0);
        chk("arst_ovf", overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ev(3);
        chk("post_rst_arm", isi_valid, 0);
        ev(3);
        chk("post_rst_valid", isi_valid, 1);
        chk("post_rst_isi", isi_data, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
